// File: rtl/sync_updown_mod_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
// Direction and mode encodings plus the load clamp.
package sync_cnt_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Out-of-range load values snap to the top of the count range.
    function automatic logic [63:0] clamp_load(input logic [63:0] val, input logic [63:0] modulo);
        return (val >= modulo) ? modulo - 64'd1 : val;
    endfunction

endpackage

// File: rtl/sync_updown_mod_counter_cell.sv
// One counter bit: synchronous reset, then load (ld/d), then toggle (t).
module cnt_tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic ld,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)     q <= 1'b0;
        else if (ld) q <= d;
        else if (t)  q <= ~q;
    end

endmodule

// File: rtl/sync_updown_mod_counter.sv
// Up/down modulo-N counter built from toggle cells with carry/borrow enable chains.
// Boundary steps (wrap or hold) and loads/clears go through the cells' load path.
module sync_updown_mod_counter
    import sync_cnt_pkg::*;
#(
    parameter int              NBITS    = 8,
    parameter longint unsigned MODULO   = 256,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             up_dn,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic             clr,
    output logic [NBITS-1:0] counter,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [NBITS-1:0] MAXV = NBITS'(MODULO - 64'd1);

    logic             step, bound, ld;
    logic [NBITS-1:0] d, lv_clamp, bound_val, carry, borrow, tgl;

    assign step      = ena & ~clr & ~load;
    assign bound     = step & ((up_dn == DIR_UP) ? (counter == MAXV) : (counter == '0));
    assign tc        = bound & ~rst;
    assign lv_clamp  = NBITS'(clamp_load(64'(load_val), 64'(MODULO)));
    assign bound_val = (SATURATE == MODE_SAT) ? counter : ((up_dn == DIR_UP) ? '0 : MAXV);
    assign ld        = clr | load | bound;

    always_comb begin
        d = bound_val;
        if (clr)       d = '0;
        else if (load) d = lv_clamp;
    end

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down), except on boundary steps.
    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign carry[i]  = 1'b1;
            assign borrow[i] = 1'b1;
        end else begin : g_chain
            assign carry[i]  = carry[i-1] & counter[i-1];
            assign borrow[i] = borrow[i-1] & ~counter[i-1];
        end
        assign tgl[i] = step & ~bound & ((up_dn == DIR_UP) ? carry[i] : borrow[i]);

        cnt_tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .ld  (ld),
            .t   (tgl[i]),
            .q   (counter[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            wrap <= bound && (SATURATE == MODE_WRAP);
            if (clr || load)
                sat <= 1'b0;
            else if (bound && (SATURATE == MODE_SAT))
                sat <= 1'b1;
        end
    end

endmodule
